// File: rtl/vga_pkg.sv
// Shared constants for the VGA scope plot: capture FSM encodings, plot window
// geometry, RGB222 colours and the sample-to-row mapping.
package vga_pkg;

   localparam logic [1:0] ST_IDLE    = 2'd0;
   localparam logic [1:0] ST_ARMED   = 2'd1;
   localparam logic [1:0] ST_CAPTURE = 2'd2;
   localparam logic [1:0] ST_DONE    = 2'd3;

   localparam int unsigned PLOT_X0_C  = 140;
   localparam int unsigned PLOT_LEN_C = 1000;
   localparam int unsigned PLOT_Y0_C  = 48;
   localparam int unsigned PLOT_Y1_C  = 624;
   localparam int unsigned AXIS_ROW_C = 336;
   localparam int unsigned Y_BASE_C   = 592;

   localparam logic [5:0] RGB_BLACK = 6'b00_00_00;
   localparam logic [5:0] RGB_WHITE = 6'b11_11_11;
   localparam logic [5:0] RGB_GRID  = 6'b01_01_01;
   localparam logic [5:0] RGB_AXIS  = 6'b10_10_10;
   localparam logic [5:0] RGB_TRACE = 6'b00_11_00;

   // Stage-1 side information that travels alongside the RAM read.
   typedef struct packed {
      logic [10:0] ypos;
      logic        in_win;
      logic        first_col;
   } rd_stage_t;

   function automatic logic [10:0] sample_row(input logic [10:0] y_base,
                                              input logic [7:0]  s);
      return y_base - {2'b00, s, 1'b0};
   endfunction

endpackage

// File: rtl/trace_ram.sv
// Simple dual-port sample store, 2048x8 addressed as {bank, index}.
// Synchronous write, registered read; contents are not reset.
module trace_ram (
   input  logic        clk_i,
   input  logic        we_i,
   input  logic [10:0] waddr_i,
   input  logic [7:0]  wdata_i,
   input  logic [10:0] raddr_i,
   output logic [7:0]  rd_data_o
);

   logic [7:0] mem_q [0:2047];

   always_ff @(posedge clk_i) begin
      if (we_i) begin
         mem_q[waddr_i] <= wdata_i;
      end
      rd_data_o <= mem_q[raddr_i];
   end

endmodule

// File: rtl/vga_trace_ctrl.sv
// Scope trace controller: level/auto trigger, ping-pong record capture that
// swaps banks only at frame start, and a 2-cycle per-pixel trace_hit path.
module vga_trace_ctrl
   import vga_pkg::*;
#(
   parameter int unsigned PLOT_X0      = PLOT_X0_C,
   parameter int unsigned PLOT_LEN     = PLOT_LEN_C,
   parameter int unsigned Y_BASE       = Y_BASE_C,
   parameter logic [15:0] AUTO_TIMEOUT = 16'd50000
) (
   input  logic        pixel_clk,
   input  logic        sys_rst_n,
   input  logic        run,
   input  logic        trig_auto,
   input  logic [7:0]  trig_level,
   input  logic        sample_valid,
   input  logic [7:0]  sample_data,
   input  logic [10:0] pixel_xpos,
   input  logic [10:0] pixel_ypos,
   output logic        trace_hit,
   output logic [1:0]  cap_state,
   output logic        frame_swap,
   output logic        trig_forced
);

   // sample_valid qualifies sample_data for exactly one cycle; there is no
   // ready/backpressure, so samples arriving in IDLE or DONE are dropped.

   logic [1:0]  state_q, state_d;
   logic [9:0]  wr_addr_q, wr_addr_d;
   logic [15:0] cnt_q, cnt_d;
   logic [7:0]  prev_q, prev_d;
   logic        prev_vld_q, prev_vld_d;
   logic        cap_forced_q, cap_forced_d;
   logic        disp_bank_q, disp_bank_d;
   logic        forced_q, forced_d;
   logic        swap_q, swap_d;

   logic        wr_en;
   logic [9:0]  wr_idx;
   logic [15:0] cnt_inc;
   logic        lvl_trig;
   logic        tmo_trig;
   logic        frame_start;

   assign frame_start = (pixel_xpos == 11'd0) && (pixel_ypos == 11'd0);
   assign cnt_inc     = cnt_q + 16'd1;
   // The first sample after arming only seeds prev and can never trigger.
   assign lvl_trig    = prev_vld_q && (prev_q < trig_level) &&
                        (sample_data >= trig_level);
   assign tmo_trig    = trig_auto && (cnt_inc == AUTO_TIMEOUT);

   always_comb begin
      state_d      = state_q;
      wr_addr_d    = wr_addr_q;
      cnt_d        = cnt_q;
      prev_d       = prev_q;
      prev_vld_d   = prev_vld_q;
      cap_forced_d = cap_forced_q;
      disp_bank_d  = disp_bank_q;
      forced_d     = forced_q;
      swap_d       = 1'b0;
      wr_en        = 1'b0;
      wr_idx       = wr_addr_q;
      case (state_q)
         ST_IDLE: begin
            if (run) begin
               state_d    = ST_ARMED;
               cnt_d      = '0;
               prev_vld_d = 1'b0;
            end
         end
         ST_ARMED: begin
            if (!run) begin
               state_d = ST_IDLE;
            end else if (sample_valid) begin
               prev_d     = sample_data;
               prev_vld_d = 1'b1;
               if (trig_auto) begin
                  cnt_d = cnt_inc;
               end
               if (lvl_trig || tmo_trig) begin
                  wr_en        = 1'b1;
                  wr_idx       = '0;
                  wr_addr_d    = 10'd1;
                  cap_forced_d = ~lvl_trig;
                  state_d      = ST_CAPTURE;
               end
            end
         end
         ST_CAPTURE: begin
            if (!run) begin
               state_d = ST_IDLE;
            end else if (sample_valid) begin
               wr_en = 1'b1;
               if (wr_addr_q == 10'(PLOT_LEN - 1)) begin
                  state_d = ST_DONE;
               end else begin
                  wr_addr_d = wr_addr_q + 10'd1;
               end
            end
         end
         default: begin
            // Bank flip only at frame start keeps the displayed record whole.
            if (frame_start) begin
               disp_bank_d = ~disp_bank_q;
               swap_d      = 1'b1;
               forced_d    = cap_forced_q;
               cnt_d       = '0;
               prev_vld_d  = 1'b0;
               state_d     = run ? ST_ARMED : ST_IDLE;
            end
         end
      endcase
   end

   always_ff @(posedge pixel_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         state_q      <= ST_IDLE;
         wr_addr_q    <= '0;
         cnt_q        <= '0;
         prev_q       <= '0;
         prev_vld_q   <= 1'b0;
         cap_forced_q <= 1'b0;
         disp_bank_q  <= 1'b0;
         forced_q     <= 1'b0;
         swap_q       <= 1'b0;
      end else begin
         state_q      <= state_d;
         wr_addr_q    <= wr_addr_d;
         cnt_q        <= cnt_d;
         prev_q       <= prev_d;
         prev_vld_q   <= prev_vld_d;
         cap_forced_q <= cap_forced_d;
         disp_bank_q  <= disp_bank_d;
         forced_q     <= forced_d;
         swap_q       <= swap_d;
      end
   end

   logic [9:0]  rd_idx;
   logic        in_win;
   rd_stage_t   rd_q, rd_d;
   logic [7:0]  rd_data;
   logic [7:0]  prev_s_q;
   logic [10:0] row_cur, row_prev, row_lo, row_hi;
   logic        hit_d, hit_q;

   assign rd_idx = 10'(pixel_xpos - 11'(PLOT_X0));
   assign in_win = (pixel_xpos >= 11'(PLOT_X0)) &&
                   (pixel_xpos <  11'(PLOT_X0 + PLOT_LEN));

   always_comb begin
      rd_d           = '0;
      rd_d.ypos      = pixel_ypos;
      rd_d.in_win    = in_win;
      rd_d.first_col = (rd_idx == 10'd0);
   end

   // Capture always writes the bank the display is not reading.
   trace_ram u_trace_ram (
      .clk_i     (pixel_clk),
      .we_i      (wr_en),
      .waddr_i   ({~disp_bank_q, wr_idx}),
      .wdata_i   (sample_data),
      .raddr_i   ({disp_bank_q, rd_idx}),
      .rd_data_o (rd_data)
   );

   always_comb begin
      row_cur  = sample_row(11'(Y_BASE), rd_data);
      row_prev = rd_q.first_col ? row_cur : sample_row(11'(Y_BASE), prev_s_q);
      row_lo   = (row_cur < row_prev) ? row_cur  : row_prev;
      row_hi   = (row_cur < row_prev) ? row_prev : row_cur;
      hit_d    = rd_q.in_win && (rd_q.ypos >= row_lo) && (rd_q.ypos <= row_hi);
   end

   always_ff @(posedge pixel_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         rd_q     <= '0;
         prev_s_q <= '0;
         hit_q    <= 1'b0;
      end else begin
         rd_q     <= rd_d;
         prev_s_q <= rd_data;
         hit_q    <= hit_d;
      end
   end

   assign trace_hit   = hit_q;
   assign cap_state   = state_q;
   assign frame_swap  = swap_q;
   assign trig_forced = forced_q;

endmodule

// File: doc/vga_trace_ctrl.md
# vga_trace_ctrl

Capture-and-display controller for the oscilloscope trace on the 1280x720 VGA plot. It takes an 8-bit sample stream, triggers on a rising level crossing, and captures one 1000-sample record into a ping-pong buffer. The buffer swaps banks only at frame start, so the display never shows a torn trace. Per pixel it produces `trace_hit`, which the pixel colour stage ORs over the grid/axis layers.

## Interface
Parameters:
- `PLOT_X0`, 140: first plot column; sample index 0 is drawn here.
- `PLOT_LEN`, 1000: samples per record; plot columns `PLOT_X0`..`PLOT_X0+PLOT_LEN-1`.
- `Y_BASE`, 592: screen row for sample value 0; row = `Y_BASE - 2*sample` (128 maps to row 336, the horizontal axis).
- `AUTO_TIMEOUT`, 16'd50000: accepted samples to wait in auto mode before a forced trigger.

Ports:
- `pixel_clk` in 1: single clock; all logic on its rising edge.
- `sys_rst_n` in 1: asynchronous, active-low reset.
- `run` in 1: 1 = acquire continuously; 0 = stop.
- `trig_auto` in 1: 1 = auto mode (forced trigger on timeout); 0 = normal mode.
- `trig_level` in 8: trigger threshold.
- `sample_valid` in 1: qualifies `sample_data` for one cycle.
- `sample_data` in 8: unsigned sample.
- `pixel_xpos` in 11: current pixel column from the timing generator.
- `pixel_ypos` in 11: current pixel row.
- `trace_hit` out 1: pixel lies on the trace; valid 2 cycles after its coordinates.
- `cap_state` out 2: FSM state encoding (see Operation).
- `frame_swap` out 1: 1-cycle pulse when the display bank changes.
- `trig_forced` out 1: last displayed record was auto-forced; updated at swap.

## Operation
- FSM: IDLE=0, ARMED=1, CAPTURE=2, DONE=3.
- IDLE: exits to ARMED when `run`=1.
- ARMED: on each valid sample, compare with the previous valid sample `prev`.
  - Trigger when `prev < trig_level` and `sample_data >= trig_level`.
  - The triggering sample is written to address 0 and the state moves to CAPTURE.
  - The first valid sample after entering ARMED only loads `prev`; it cannot trigger.
- Auto mode: a 16-bit counter increments on each valid sample in ARMED.
  - When the count reaches `AUTO_TIMEOUT`, the current sample is treated as the trigger and the forced flag is set.
  - The counter clears on entry to ARMED.
- CAPTURE: each valid sample is written to the capture bank at `wr_addr` (0..`PLOT_LEN`-1). After writing index `PLOT_LEN`-1, the state moves to DONE.
- DONE: ignores samples.
  - At frame start (`pixel_xpos`==0 and `pixel_ypos`==0): toggle the display bank, pulse `frame_swap`, and latch `trig_forced`.
  - The next state is ARMED if `run`=1, else IDLE.
- `run`=0 in ARMED or CAPTURE aborts to IDLE next cycle. No swap occurs and the partial record is discarded.
- Frame start while not in DONE: no swap; the display keeps the old bank.
- Drawing: for a column inside the plot window, read sample s[i] and the previous column's sample s[i-1]. Compute rows r = `Y_BASE` - 2·s[i] and rp = `Y_BASE` - 2·s[i-1].
  - `trace_hit`=1 when `pixel_ypos` lies between min(r,rp) and max(r,rp) inclusive, which draws a continuous vertical segment.
  - For the first column (i=0), rp=r.
  - Outside the plot window, `trace_hit`=0.
- Arithmetic: rows are computed at 11 bits; `2*sample` is `{2'b0, s, 1'b0}`. No underflow is possible for `Y_BASE` ≥ 510.

## Timing
- Reset values: state IDLE; `trace_hit`, `frame_swap`, `trig_forced` = 0; display bank 0; capture bank 1; `wr_addr` and counter = 0; `cap_state`=0.
- Sample write occurs on the same edge as `sample_valid`.
- Display read path:
  - Cycle 0: the address is formed from `pixel_xpos - PLOT_X0`; `pixel_ypos` is registered.
  - Cycle 1: RAM data and the held previous-column sample are available.
  - Cycle 2: `trace_hit` is registered.
  - Total latency is 2 cycles; the colour stage delays its own layers to match.
- `frame_swap` is asserted in the cycle after the frame-start coordinate is seen in DONE.
- Write and read ports are independent and always target different banks, so there are no collisions.

## Structure
- Shared package/include `vga_pkg`: FSM state encodings, the plot window constants (140, 1000, 48, 624, axis row 336), and the RGB222 colour constants.
- Sub-module `trace_ram`: simple dual-port RAM, 2048x8 ({bank, 10-bit index}).
  - Synchronous write.
  - Registered read, 1-cycle latency.
  - No reset on contents.

## Test plan
- Ramp 0..255 repeating, level 100, normal mode → trigger on 99→100. Address 0 = 100, address 999 = (100+999) mod 256 = 75; `frame_swap` fires once at the next (0,0).
- Constant 50, level 100, auto mode, timeout 16 → forced trigger on the 16th valid sample; `trig_forced`=1 after the swap. In normal mode, the FSM stays in ARMED.
- Display bank loaded with 128 everywhere → `trace_hit`=1 only at row 336, x 140..1139, 2 cycles after the coordinate. Zero at x=139 and x=1140.
- Adjacent samples 0 then 255 at indices 9/10 → column 150 hits rows 82..592 inclusive.
- `run` dropped at capture index 500 → IDLE, no `frame_swap` for 3 frames; the display remains the previous record.
- `sys_rst_n` pulsed low mid-CAPTURE → all outputs 0 immediately, state IDLE, display bank 0.
